score_bram_scheduler: RTL
=========================

SCORE_BRAM_SCHEDULER -- requirements
Module: score_bram_scheduler

Interface
REQ-001 SHALL have parameters, one per line, as name, default, meaning:
  NUM_ENG, 4, number of diffusion engines.
  ADDR_WIDTH, 13, score BRAM address width.
  DATA_WIDTH, 32, score word and l_step width.
  MAX_STEPS, 7, walk-step count.
  TIMEOUT_CYCLES, 64, grant watchdog limit.
REQ-002 SHALL have ports, one per line, as name, direction, width, meaning. Clock and reset come first.
  clk  in  1  single clock; all logic on posedge.
  rst  in  1  synchronous, active-high reset.
  start  in  1  one-cycle pulse that begins a run.
  req  in  NUM_ENG  per-engine score-port request.
  we_in  in  NUM_ENG  per-engine write enable.
  addr_in  in  NUM_ENG*ADDR_WIDTH  packed engine addresses; engine i at [i*ADDR_WIDTH +: ADDR_WIDTH].
  wdata_in  in  NUM_ENG*DATA_WIDTH  packed engine write data.
  finished_in  in  NUM_ENG  engine end-of-step flag.
  bram_dout  in  DATA_WIDTH  BRAM read data, 1-cycle latency.
  rdy  out  NUM_ENG  one-hot grant.
  conflict  out  NUM_ENG  request denied this cycle.
  rdata_out  out  DATA_WIDTH  bram_dout broadcast to all engines.
  bram_en, bram_we  out  1 each  BRAM port enable and write enable.
  bram_addr  out  ADDR_WIDTH  BRAM port address.
  bram_din  out  DATA_WIDTH  BRAM write data.
  l_step  out  DATA_WIDTH  current walk step.
  all_done  out  1  run complete.
  timeout_err  out  1  sticky watchdog flag.

Function
REQ-003 SHALL implement the states IDLE, RUN, STEP_SYNC and DONE.
REQ-004 In IDLE, start SHALL move the FSM to RUN and set l_step=0. In any other state, start SHALL be ignored.
REQ-005 In RUN, grant SHALL be round-robin. Search SHALL begin at the engine after the last granted one. When no prior grant exists, search SHALL begin at engine 0.
REQ-006 A grant SHALL take effect the cycle after req is sampled. rdy[i] SHALL stay high while req[i] stays high. The grant SHALL release the cycle after req[i] falls.
REQ-007 conflict[i] SHALL be high exactly when req[i]=1 and rdy[i]=0 in that cycle. It SHALL not be registered.
REQ-008 While rdy[g]=1, the BRAM outputs SHALL be driven combinationally: bram_en=1, bram_we=we_in[g], bram_addr=addr_in[g], bram_din=wdata_in[g]. With no grant, bram_en=0 and bram_we=0.
REQ-009 rdata_out SHALL equal bram_dout. It is valid one cycle after a granted read.
REQ-010 finished_in[i] SHALL set sticky bit done_q[i]. The bit SHALL be cleared only in STEP_SYNC or by reset.
REQ-011 When done_q is all ones and no grant is active, the FSM SHALL go from RUN to STEP_SYNC.
REQ-012 STEP_SYNC SHALL last one cycle.
  - It SHALL clear done_q and drive rdy=0.
  - If l_step+1 == MAX_STEPS, the next state SHALL be DONE and l_step SHALL hold.
  - Otherwise l_step SHALL increment and the FSM SHALL return to RUN.
REQ-013 In DONE, all_done SHALL be 1 and no grants SHALL be issued. start SHALL return the FSM to IDLE, where all_done=0.
REQ-014 When finished_in and req from the same engine arrive in the same cycle, both SHALL be honoured. The sticky set and the grant are independent.
REQ-015 In IDLE, STEP_SYNC and DONE, every asserted req SHALL see conflict=1.

Reset
REQ-016 When rst=1 at a posedge, the following SHALL apply on the next cycle regardless of state:
  - state=IDLE, rdy=0, l_step=0, all_done=0.
  - done_q=0, timeout_err=0, round-robin pointer=NUM_ENG-1.
  - bram_en=0 and bram_we=0.
REQ-017 A reset taken mid-grant SHALL drop the grant. It SHALL not issue a BRAM write in that cycle.

Configuration
REQ-018 Macro SCHED_TIMEOUT_EN SHALL enable the grant watchdog.
  - Defined: a grant held TIMEOUT_CYCLES consecutive cycles SHALL be revoked and the arbiter SHALL rotate to the next requester. timeout_err SHALL be set and stay set until reset.
  - Undefined: a grant SHALL be held indefinitely and timeout_err SHALL be tied to 0.

Structure
REQ-019 Package diff_sched_pkg SHALL hold:
  - the state enum;
  - the default widths;
  - the STEP_SYNC/DONE encodings.
REQ-020 Round-robin selection SHALL live in a sub-module named rr_arbiter. Its interface SHALL be req, grant-enable and last-pointer in, one-hot grant out.

Verification
REQ-021 Reset then start, NUM_ENG=4, req=4'b0101 held → rdy=4'b0001 the next cycle, conflict=4'b0100, bram_en=1.
REQ-022 Engine 0 drops req while req[2] stays high → rdy=4'b0100 one cycle later. Engine 0 re-requests → it waits until req[2] falls.
REQ-023 Granted write with addr 0x014 and data 0x0000_00A5 → bram_we=1, bram_addr=0x014, bram_din=0xA5 in the same cycle. A read of 0x014 → rdata_out=0xA5 one cycle later.
REQ-024 finished_in pulsed on engines 0..3 in cycles 3, 5, 5, 9 → STEP_SYNC in cycle 10 and l_step=1 in cycle 11. After 7 step completions → all_done=1 and l_step=6.
REQ-025 With SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=64, engine 1 holds req for 100 cycles while engine 3 also requests → rdy rotates to engine 3 at grant cycle 64 and timeout_err=1. Without the macro → engine 1 keeps the grant and timeout_err=0.
REQ-026 rst asserted during a granted write → rdy=0, bram_we=0 and state=IDLE on the next cycle.

Source files
------------

// File: rtl/diff_sched_pkg.sv
// Shared definitions for the score BRAM scheduler: default widths,
// FSM state encodings and a pointer-width helper.
package diff_sched_pkg;

    localparam int DEF_NUM_ENG        = 4;
    localparam int DEF_ADDR_WIDTH     = 13;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_MAX_STEPS      = 7;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    localparam logic [1:0] ENC_IDLE      = 2'd0;
    localparam logic [1:0] ENC_RUN       = 2'd1;
    localparam logic [1:0] ENC_STEP_SYNC = 2'd2;
    localparam logic [1:0] ENC_DONE      = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = ENC_IDLE,
        RUN       = ENC_RUN,
        STEP_SYNC = ENC_STEP_SYNC,
        DONE      = ENC_DONE
    } sched_state_e;

    // Width of an engine index; at least one bit so a single engine still works.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requester strictly after last_ptr,
// wrapping around, and returns it as a one-hot grant.
module rr_arbiter #(
    parameter int NUM_ENG = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_ENG-1:0] req,
    input  logic               grant_en,
    input  logic [PTR_W-1:0]   last_ptr,
    output logic [NUM_ENG-1:0] grant
);

    logic [PTR_W:0]       shamt;
    logic [NUM_ENG-1:0]   rot_req;
    logic [NUM_ENG-1:0]   rot_oh;

    // Rotate so the engine after last_ptr lands at bit 0, take the lowest set
    // bit, then rotate the one-hot result back into engine order.
    always_comb begin
        shamt   = {1'b0, last_ptr} + {{PTR_W{1'b0}}, 1'b1};
        rot_req = NUM_ENG'({req, req} >> shamt);
        rot_oh  = rot_req & (-rot_req);
        grant   = grant_en ? NUM_ENG'(({rot_oh, rot_oh} << shamt) >> NUM_ENG) : '0;
    end

endmodule

// File: rtl/score_bram_scheduler.sv
// Score BRAM scheduler: arbitrates one BRAM port among NUM_ENG diffusion
// engines and sequences MAX_STEPS walk steps.
// Optional grant watchdog enabled by defining SCHED_TIMEOUT_EN.
module score_bram_scheduler
    import diff_sched_pkg::*;
#(
    parameter int NUM_ENG        = DEF_NUM_ENG,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int MAX_STEPS      = DEF_MAX_STEPS,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [NUM_ENG-1:0]            req,
    input  logic [NUM_ENG-1:0]            we_in,
    input  logic [NUM_ENG*ADDR_WIDTH-1:0] addr_in,
    input  logic [NUM_ENG*DATA_WIDTH-1:0] wdata_in,
    input  logic [NUM_ENG-1:0]            finished_in,
    input  logic [DATA_WIDTH-1:0]         bram_dout,
    output logic [NUM_ENG-1:0]            rdy,
    output logic [NUM_ENG-1:0]            conflict,
    output logic [DATA_WIDTH-1:0]         rdata_out,
    output logic                          bram_en,
    output logic                          bram_we,
    output logic [ADDR_WIDTH-1:0]         bram_addr,
    output logic [DATA_WIDTH-1:0]         bram_din,
    output logic [DATA_WIDTH-1:0]         l_step,
    output logic                          all_done,
    output logic                          timeout_err
);

    localparam int PTR_W = ptr_width(NUM_ENG);

    sched_state_e           state_q, state_d;
    logic [NUM_ENG-1:0]     grant_q, grant_d;
    logic [NUM_ENG-1:0]     done_q, done_d;
    logic [PTR_W-1:0]       last_q, last_d;
    logic [DATA_WIDTH-1:0]  l_step_q, l_step_d;
    logic [NUM_ENG-1:0]     arb_req, arb_grant;
    logic [PTR_W-1:0]       arb_idx;
    logic                   expire;

    // A timed-out holder is masked so the search moves on to the next requester.
    assign arb_req = expire ? (req & ~grant_q) : req;

    rr_arbiter #(
        .NUM_ENG (NUM_ENG),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req      (arb_req),
        .grant_en (state_q == RUN),
        .last_ptr (last_q),
        .grant    (arb_grant)
    );

    // One-hot arbiter result to engine index for the round-robin pointer.
    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < NUM_ENG; i++) begin
            if (arb_grant[i]) arb_idx = PTR_W'(i);
        end
    end

    // Next-state logic: run control, step sequencing, grant hold/handover.
    always_comb begin
        state_d  = state_q;
        l_step_d = l_step_q;
        done_d   = done_q | finished_in;
        grant_d  = '0;
        last_d   = last_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    l_step_d = '0;
                end
            end
            RUN: begin
                // A finish arriving this cycle counts, so the step closes one cycle sooner.
                if (!(|grant_q) && (&done_d)) begin
                    state_d = STEP_SYNC;
                end else if ((|(grant_q & req)) && !expire) begin
                    grant_d = grant_q;
                end else begin
                    grant_d = arb_grant;
                    if (|arb_grant) last_d = arb_idx;
                end
            end
            STEP_SYNC: begin
                done_d = '0;
                if (l_step_q + DATA_WIDTH'(1) == DATA_WIDTH'(MAX_STEPS)) begin
                    state_d = DONE;
                end else begin
                    l_step_d = l_step_q + DATA_WIDTH'(1);
                    state_d  = RUN;
                end
            end
            DONE: begin
                if (start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, grant, pointer, sticky finish bits and step counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            done_q   <= '0;
            last_q   <= PTR_W'(NUM_ENG - 1);
            l_step_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            last_q   <= last_d;
            l_step_q <= l_step_d;
        end
    end

`ifdef SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             timeout_err_q;

    assign expire = (|grant_q) && (hold_cnt_q == CNT_W'(TIMEOUT_CYCLES));

    // Counts the cycles the current grant has been held; a new holder starts at one.
    always_comb begin
        if (grant_d == '0)          hold_cnt_d = '0;
        else if (grant_d == grant_q) hold_cnt_d = hold_cnt_q + CNT_W'(1);
        else                         hold_cnt_d = CNT_W'(1);
    end

    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            hold_cnt_q    <= hold_cnt_d;
            timeout_err_q <= timeout_err_q | expire;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
    assign expire         = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    logic [ADDR_WIDTH-1:0] eng_addr [NUM_ENG];
    logic [DATA_WIDTH-1:0] eng_din  [NUM_ENG];
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_din;

    for (genvar gi = 0; gi < NUM_ENG; gi++) begin : g_eng
        assign eng_addr[gi] = grant_q[gi] ? addr_in[gi*ADDR_WIDTH +: ADDR_WIDTH] : '0;
        assign eng_din[gi]  = grant_q[gi] ? wdata_in[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
    end

    // OR-combine the masked engine buses; the grant is one-hot so at most one is non-zero.
    always_comb begin
        sel_addr = '0;
        sel_din  = '0;
        for (int i = 0; i < NUM_ENG; i++) begin
            sel_addr = sel_addr | eng_addr[i];
            sel_din  = sel_din  | eng_din[i];
        end
    end

    // Reset gates the port so a grant caught by reset cannot commit a write.
    assign bram_en   = (|grant_q) & ~rst;
    assign bram_we   = (|(grant_q & we_in)) & ~rst;
    assign bram_addr = sel_addr;
    assign bram_din  = sel_din;

    assign rdy       = grant_q;
    assign conflict  = req & ~grant_q;
    assign rdata_out = bram_dout;
    assign l_step    = l_step_q;
    assign all_done  = (state_q == DONE);

endmodule
